// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder slice.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell used as the serial adder's arithmetic core.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic s
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: feeds one operand bit pair per clock, LSB first, through
// a full_adder with a registered carry; result bits shift in from the MSB side.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q;
  logic             busy_q, done_q;
  logic             fa_co, fa_s;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .cout (fa_co),
    .s    (fa_s)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          carry_q <= fa_co;
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) cout_q <= fa_co;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed 8-bit vectors plus an
// exhaustive 4-bit sweep; a monitor per instance checks every done pulse.
module tb_serial_adder;

  typedef struct {
    logic [8:0] exp;
    int         e0;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;
  int  done_cnt8 = 0;
  int  bd_viol = 0;
  sb_t q8[$];
  sb_t q4[$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop on every done pulse and compare result and latency.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy8 && done8) bd_viol++;
      if (done8) begin
        sb_t e;
        done_cnt8++;
        if (q8.size() == 0) begin
          chk("w8_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          chk("w8_result", {23'd0, cout8, sum8}, {23'd0, e.exp});
          chk("w8_latency", cyc - e.e0, 32'd8);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy4 && done4) bd_viol++;
      if (done4) begin
        sb_t e;
        if (q4.size() == 0) begin
          chk("w4_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          chk("w4_result", {27'd0, cout4, sum4}, {27'd0, e.exp[4:0]});
          chk("w4_latency", cyc - e.e0, 32'd4);
        end
      end
    end
  end

  // Caller is at posedge+#1; start is sampled on the next edge (E0).
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp, input bit push);
    sb_t e;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    if (push) begin
      e.exp = exp; e.e0 = cyc + 1;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic drain8(input string name);
    int t = 0;
    while (q8.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (q8.size() != 0) begin
      chk(name, q8.size(), 32'd0);
      q8.delete();
    end
  endtask

  task automatic drain4();
    int t = 0;
    while (q4.size() != 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (q4.size() != 0) begin
      chk("w4_timeout", q4.size(), 32'd0);
      q4.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int nb, nd, d0;
    sb_t e;

    #2;
    chk("reset_busy", {31'd0, busy8}, 32'd0);
    chk("reset_done", {31'd0, done8}, 32'd0);
    chk("reset_sum", {24'd0, sum8}, 32'd0);
    chk("reset_cout", {31'd0, cout8}, 32'd0);
    chk("reset_w4", {26'd0, busy4, done4, cout4, sum4}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with busy-width and single done check.
    d0 = done_cnt8;
    issue8(8'h12, 8'h34, 1'b0, 9'h046, 1'b1);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy8) nb++;
    end
    chk("busy_cycles", nb, 32'd8);
    chk("done_pulses_basic", done_cnt8 - d0, 32'd1);
    drain8("basic_timeout");
    @(posedge clk); #1;

    issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    drain8("ff01_timeout");
    @(posedge clk); #1;
    issue8(8'h5A, 8'hA5, 1'b1, 9'h100, 1'b1);
    drain8("5aa5_timeout");
    @(posedge clk); #1;

    // Start mid-run is ignored; operand changes have no effect.
    d0 = done_cnt8;
    issue8(8'h0F, 8'h01, 1'b0, 9'h010, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h77;
    drain8("ignore_timeout");
    repeat (12) begin @(posedge clk); #1; end
    chk("done_pulses_ignore", done_cnt8 - d0, 32'd1);

    // Start held high: one acceptance per WIDTH+2 cycles.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.exp = 9'h002; e.e0 = cyc + 1 + 10 * k;
      q8.push_back(e);
    end
    drain8("hold_timeout");
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset mid-run clears outputs immediately and suppresses done.
    d0 = done_cnt8;
    issue8(8'h33, 8'h44, 1'b0, 9'h0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_busy", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy8}, 32'd0);
    chk("midrst_done", {31'd0, done8}, 32'd0);
    chk("midrst_sum", {24'd0, sum8}, 32'd0);
    chk("midrst_cout", {31'd0, cout8}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("no_done_after_reset", done_cnt8 - d0, 32'd0);
    issue8(8'h80, 8'h80, 1'b1, 9'h101, 1'b1);
    drain8("post_reset_timeout");
    @(posedge clk); #1;

    // Exhaustive sweep on the 4-bit instance.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
          e.exp = 9'(a + b + c); e.e0 = cyc + 1;
          q4.push_back(e);
          @(posedge clk); #1;
          start4 = 1'b0;
          drain4();
        end
      end
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("busy_done_overlap", bd_viol, 32'd0);
    chk("q8_leftover", q8.size(), 32'd0);
    chk("q4_leftover", q4.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
